// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_e;

  localparam logic HI_SEL = 1'b0;
  localparam logic LO_SEL = 1'b1;

  // Divide-by-zero LO value; sliced to the operand width at the use site.
  localparam logic [63:0] DIV0_LO = '1;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the shift-add multiplier / restoring divider.
// Multiply: acc += a when b[0]; a shifts left, b shifts right.
// Divide:   acc = {quotient, remainder}; the next dividend bit is a[WIDTH-1].
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               op_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] a_o,
  output logic [WIDTH-1:0]   b_o
);

  logic [WIDTH:0] trial;

  // One multiply add-and-shift or one restoring trial subtraction.
  always_comb begin
    trial = {acc_i[WIDTH-1:0], a_i[WIDTH-1]} - {1'b0, b_i};
    acc_o = acc_i;
    a_o   = {a_i[2*WIDTH-2:0], 1'b0};
    b_o   = b_i;
    if (op_div_i) begin
      // Negative trial means the divisor did not fit: keep the shifted remainder.
      if (!trial[WIDTH]) begin
        acc_o = {acc_i[2*WIDTH-2:WIDTH], 1'b1, trial[WIDTH-1:0]};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:WIDTH], 1'b0, acc_i[WIDTH-2:0], a_i[WIDTH-1]};
      end
    end else begin
      acc_o = acc_i + (b_i[0] ? a_i : '0);
      b_o   = b_i >> 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN as soon as
// the remaining multiplier bits are all zero.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             hilo_rd_i,
  input  logic             hi0_lo1_sel_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hilo_rd_data_o,
  output logic             hilo_read_done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e               state_q;
  logic                 busy_q;
  logic                 dz_q;
  logic                 op_div_q;
  logic                 sa_q;
  logic                 sb_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic                 bzero_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     orig_a_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [2*WIDTH-1:0]   acc_n;
  logic [2*WIDTH-1:0]   a_n;
  logic [WIDTH-1:0]     b_n;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;
  logic [2*WIDTH-1:0]   prod;
  logic                 run_done;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div_i (op_div_q),
    .acc_i    (acc_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .acc_o    (acc_n),
    .a_o      (a_n),
    .b_o      (b_n)
  );

  // Operand magnitudes; unsigned ops pass through untouched.
  always_comb begin
    mag_a = (signed_i && opa_i[WIDTH-1]) ? ('0 - opa_i) : opa_i;
    mag_b = (signed_i && opb_i[WIDTH-1]) ? ('0 - opb_i) : opb_i;
  end

  // Last RUN iteration detection.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    run_done = (cnt_q == '0) || (!op_div_q && (b_n == '0));
`else
    run_done = (cnt_q == '0);
`endif
  end

  // Sign-corrected HI/LO results written when FIX retires.
  always_comb begin
    prod = neg_q_q ? ('0 - acc_q) : acc_q;
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (op_div_q) begin
      if (bzero_q) begin
        hi_d = orig_a_q;
        lo_d = DIV0_LO[WIDTH-1:0];
      end else begin
        lo_d = neg_q_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        hi_d = neg_r_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      end
    end
  end

  // Sequencer FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      op_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      dz_q <= 1'b0;
      if (flush_i && (state_q != IDLE)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !flush_i) begin
              op_div_q <= op_div_i;
              sa_q     <= signed_i & opa_i[WIDTH-1];
              sb_q     <= signed_i & opb_i[WIDTH-1];
              a_q      <= {{WIDTH{1'b0}}, mag_a};
              b_q      <= mag_b;
              orig_a_q <= opa_i;
              bzero_q  <= (opb_i == '0);
              state_q  <= PREP;
              busy_q   <= 1'b1;
            end
          end
          PREP: begin
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            neg_q_q <= sa_q ^ sb_q;
            neg_r_q <= sa_q;
            state_q <= RUN;
          end
          RUN: begin
            acc_q <= acc_n;
            a_q   <= a_n;
            b_q   <= b_n;
            if (run_done) begin
              state_q <= FIX;
              dz_q    <= op_div_q & bzero_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          FIX: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o           = busy_q;
  assign div_by_zero_o    = dz_q;
  assign stall_o          = busy_q & (hilo_rd_i | start_i);
  assign hilo_read_done_o = hilo_rd_i & ~busy_q;
  assign hilo_rd_data_o   = (hi0_lo1_sel_i == LO_SEL) ? lo_q : hi_q;
  assign hi_o             = hi_q;
  assign lo_o             = lo_q;

endmodule
